// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : shared types for the execute-side branch resolution slice
// Rev 1.0
// ============================================================================
package branch_pkg;
   localparam int unsigned INSN_BYTES = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic        hit;
      logic        taken;
      logic [63:0] target;
   } pred_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } res_state_e;
endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
// pred_fifo : in-order in-flight prediction queue; flush beats push and pop
// Rev 1.0
// ============================================================================
module pred_fifo
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  pred_entry_t      push_data,
   input  logic             pop,
   input  logic             flush,
   output pred_entry_t      head_data,
   output logic [PTR_W:0]   count,
   output logic             full
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   pred_entry_t      mem_q [DEPTH];
   pred_entry_t      mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == FULL_CNT);
   assign count     = count_q;
   assign head_data = mem_q[head_q];
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && (count_q != '0) && !flush;

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[tail_q] = push_data;
      // Pointers wrap naturally because DEPTH is a power of two
      head_d  = flush ? '0 : head_q + PTR_W'(do_pop);
      tail_d  = flush ? '0 : tail_q + PTR_W'(do_push);
      count_d = flush ? '0 : count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// branch_resolve_unit : checks fetch predictions against execute outcomes,
// issues redirects and stall-safe BTB commands. Option: BRANCH_RESOLVE_STATS_EN
// Rev 1.0
// ============================================================================
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_pred_valid,
   input  logic [63:0] in_pred_pc,
   input  logic        in_pred_hit,
   input  logic        in_pred_taken,
   input  logic [63:0] in_pred_target,
   input  logic        in_res_valid,
   input  logic        in_res_taken,
   input  logic [63:0] in_res_target,
   input  logic        in_stall,
   output logic        out_pred_ready,
   output logic        out_redirect,
   output logic [63:0] out_redirect_pc,
   output logic        out_write_to_bp,
   output logic [63:0] out_branch_source,
   output logic [63:0] out_branch_target,
   output logic        out_is_update_state,
   output logic [63:0] out_source,
`ifdef BRANCH_RESOLVE_STATS_EN
   output logic [31:0] out_stat_resolved,
   output logic [31:0] out_stat_mispredict,
`endif
   output logic        out_is_actual_branch_taken
);
   res_state_e     state_q, state_d;
   pred_entry_t    head, push_entry;
   logic [PTR_W:0] fifo_count;
   logic           fifo_full, push, pop, flush, mispredict, write_en;
   logic [63:0]    actual_pc;

   logic        redirect_q, redirect_d, write_q, write_d, update_q, update_d, dir_q, dir_d;
   logic [63:0] redirect_pc_q, redirect_pc_d, bsrc_q, bsrc_d, btgt_q, btgt_d, src_q, src_d;

   assign push_entry = '{pc: in_pred_pc, hit: in_pred_hit, taken: in_pred_taken,
                         target: in_pred_target};
   assign push  = in_pred_valid && out_pred_ready && !in_stall;
   assign pop   = in_res_valid && (fifo_count != '0) && (state_q == IDLE) && !in_stall;
   // Everything younger than a mispredicted branch is wrong-path, including a same-cycle push
   assign flush = (state_q == ISSUE) && redirect_q;

   pred_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush),
      .head_data (head),
      .count     (fifo_count),
      .full      (fifo_full)
   );

   assign out_pred_ready = !fifo_full;
   assign actual_pc  = in_res_taken ? in_res_target : head.pc + 64'(INSN_BYTES);
   assign mispredict = (head.taken != in_res_taken) ||
                       (in_res_taken && (head.target != in_res_target));
   // Allocate on a taken miss, or refresh a hit entry whose stored target is stale
   assign write_en   = in_res_taken && (!head.hit || (head.target != in_res_target));

   always_comb begin
      state_d       = state_q;
      redirect_d    = redirect_q;
      redirect_pc_d = redirect_pc_q;
      write_d       = write_q;
      bsrc_d        = bsrc_q;
      btgt_d        = btgt_q;
      update_d      = update_q;
      src_d         = src_q;
      dir_d         = dir_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d       = ISSUE;
               redirect_d    = mispredict;
               redirect_pc_d = actual_pc;
               write_d       = write_en;
               bsrc_d        = write_en ? head.pc : '0;
               btgt_d        = write_en ? in_res_target : '0;
               update_d      = head.hit;
               src_d         = head.hit ? head.pc : '0;
               dir_d         = head.hit && in_res_taken;
            end
         end
         ISSUE, HOLD: begin
            if (in_stall) begin
               state_d = HOLD;
            end else begin
               state_d       = IDLE;
               redirect_d    = 1'b0;
               redirect_pc_d = '0;
               write_d       = 1'b0;
               bsrc_d        = '0;
               btgt_d        = '0;
               update_d      = 1'b0;
               src_d         = '0;
               dir_d         = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         write_q       <= 1'b0;
         bsrc_q        <= '0;
         btgt_q        <= '0;
         update_q      <= 1'b0;
         src_q         <= '0;
         dir_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         write_q       <= write_d;
         bsrc_q        <= bsrc_d;
         btgt_q        <= btgt_d;
         update_q      <= update_d;
         src_q         <= src_d;
         dir_q         <= dir_d;
      end
   end

   assign out_redirect               = redirect_q;
   assign out_redirect_pc            = redirect_pc_q;
   assign out_write_to_bp            = write_q;
   assign out_branch_source          = bsrc_q;
   assign out_branch_target          = btgt_q;
   assign out_is_update_state        = update_q;
   assign out_source                 = src_q;
   assign out_is_actual_branch_taken = dir_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;
   logic        retire;

   assign retire = ((state_q == ISSUE) || (state_q == HOLD)) && !in_stall;

   always_comb begin
      stat_res_d = stat_res_q;
      stat_mis_d = stat_mis_q;
      if (retire && (stat_res_q != 32'hFFFF_FFFF)) stat_res_d = stat_res_q + 32'd1;
      if (retire && redirect_q && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign out_stat_resolved   = stat_res_q;
   assign out_stat_mispredict = stat_mis_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_unit : directed scoreboard bench for branch_resolve_unit
// Rev 1.0
// ============================================================================
module tb_branch_resolve_unit;
   import branch_pkg::*;

   typedef struct {
      logic        redirect;
      logic [63:0] rpc;
      logic        wr;
      logic [63:0] bsrc;
      logic [63:0] btgt;
      logic        upd;
      logic [63:0] src;
      logic        dir;
   } cmd_t;

   logic        clk, rst_n;
   logic        in_pred_valid, in_pred_hit, in_pred_taken;
   logic [63:0] in_pred_pc, in_pred_target;
   logic        in_res_valid, in_res_taken, in_stall;
   logic [63:0] in_res_target;
   logic        out_pred_ready, out_redirect, out_write_to_bp, out_is_update_state;
   logic        out_is_actual_branch_taken;
   logic [63:0] out_redirect_pc, out_branch_source, out_branch_target, out_source;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] out_stat_resolved, out_stat_mispredict;
`endif

   int tests = 0;
   int fails = 0;
   pred_entry_t model_q[$];
   cmd_t        exp_q[$];

   branch_resolve_unit #(.DEPTH(4)) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .in_pred_valid              (in_pred_valid),
      .in_pred_pc                 (in_pred_pc),
      .in_pred_hit                (in_pred_hit),
      .in_pred_taken              (in_pred_taken),
      .in_pred_target             (in_pred_target),
      .in_res_valid               (in_res_valid),
      .in_res_taken               (in_res_taken),
      .in_res_target              (in_res_target),
      .in_stall                   (in_stall),
      .out_pred_ready             (out_pred_ready),
      .out_redirect               (out_redirect),
      .out_redirect_pc            (out_redirect_pc),
      .out_write_to_bp            (out_write_to_bp),
      .out_branch_source          (out_branch_source),
      .out_branch_target          (out_branch_target),
      .out_is_update_state        (out_is_update_state),
      .out_source                 (out_source),
`ifdef BRANCH_RESOLVE_STATS_EN
      .out_stat_resolved          (out_stat_resolved),
      .out_stat_mispredict        (out_stat_mispredict),
`endif
      .out_is_actual_branch_taken (out_is_actual_branch_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pred(input logic [63:0] pc, input logic hit, input logic taken,
                            input logic [63:0] target);
      pred_entry_t e;
      e = '{pc: pc, hit: hit, taken: taken, target: target};
      if (out_pred_ready) model_q.push_back(e);
      in_pred_valid = 1'b1; in_pred_pc = pc; in_pred_hit = hit;
      in_pred_taken = taken; in_pred_target = target;
      tick();
      in_pred_valid = 1'b0;
   endtask

   // Builds the expected command from the bench's own copy of the head entry
   task automatic resolve(input logic taken, input logic [63:0] target);
      pred_entry_t e;
      cmd_t        c;
      if (model_q.size() == 0) begin
         tests++; fails++;
         $error("FAIL resolve_model_empty observed=0 expected=1");
         return;
      end
      e = model_q.pop_front();
      c.redirect = (e.taken != taken) || (taken && (e.target != target));
      c.rpc      = taken ? target : e.pc + 64'd4;
      c.wr       = taken && (!e.hit || (e.target != target));
      c.bsrc     = c.wr ? e.pc : 64'd0;
      c.btgt     = c.wr ? target : 64'd0;
      c.upd      = e.hit;
      c.src      = e.hit ? e.pc : 64'd0;
      c.dir      = e.hit && taken;
      if (c.redirect) model_q.delete();
      exp_q.push_back(c);
      in_res_valid = 1'b1; in_res_taken = taken; in_res_target = target;
      tick();
      in_res_valid = 1'b0;
   endtask

   task automatic check_cmd(input string tag, input logic pop_it);
      cmd_t c;
      if (exp_q.size() == 0) begin
         tests++; fails++;
         $error("FAIL %s_scoreboard_empty observed=0 expected=1", tag);
         return;
      end
      c = pop_it ? exp_q.pop_front() : exp_q[0];
      chk({tag, "_redirect"},    64'(out_redirect), 64'(c.redirect));
      chk({tag, "_redirect_pc"}, out_redirect_pc, c.rpc);
      chk({tag, "_write"},       64'(out_write_to_bp), 64'(c.wr));
      chk({tag, "_bsrc"},        out_branch_source, c.bsrc);
      chk({tag, "_btgt"},        out_branch_target, c.btgt);
      chk({tag, "_update"},      64'(out_is_update_state), 64'(c.upd));
      chk({tag, "_src"},         out_source, c.src);
      chk({tag, "_dir"},         64'(out_is_actual_branch_taken), 64'(c.dir));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_redirect"}, 64'(out_redirect), 64'd0);
      chk({tag, "_redirect_pc"}, out_redirect_pc, 64'd0);
      chk({tag, "_write"}, 64'(out_write_to_bp), 64'd0);
      chk({tag, "_bsrc"}, out_branch_source, 64'd0);
      chk({tag, "_btgt"}, out_branch_target, 64'd0);
      chk({tag, "_update"}, 64'(out_is_update_state), 64'd0);
      chk({tag, "_src"}, out_source, 64'd0);
      chk({tag, "_dir"}, 64'(out_is_actual_branch_taken), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_pred_valid = 1'b0; in_pred_pc = '0; in_pred_hit = 1'b0;
      in_pred_taken = 1'b0; in_pred_target = '0; in_res_valid = 1'b0;
      in_res_taken = 1'b0; in_res_target = '0; in_stall = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      chk("reset_count", 64'(dut.u_fifo.count_q), 64'd0);
      rst_n = 1'b1;
      tick();

      // hit, predicted taken, correct
      push_pred(64'h1000, 1'b1, 1'b1, 64'h2000);
      resolve(1'b1, 64'h2000);
      check_cmd("hit_taken", 1'b1);
      tick();
      check_idle("hit_taken_clear");

      // miss, predicted not taken, actually taken
      push_pred(64'h1400, 1'b0, 1'b0, 64'h0);
      resolve(1'b1, 64'h3000);
      check_cmd("miss_taken", 1'b1);
      tick();
      check_idle("miss_taken_clear");
      chk("miss_taken_count", 64'(dut.u_fifo.count_q), 64'd0);

      // wrap of pc + 4
      push_pred(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 64'h5000);
      resolve(1'b0, 64'h0);
      check_cmd("wrap", 1'b1);
      tick();

      // hit with stale target: write and update together
      push_pred(64'h3000, 1'b1, 1'b1, 64'h3100);
      resolve(1'b1, 64'h3200);
      check_cmd("stale_tgt", 1'b1);
      tick();

      // three stalled cycles, then one unstalled hold cycle
      push_pred(64'h2000, 1'b1, 1'b1, 64'h2400);
      resolve(1'b1, 64'h2400);
      in_stall = 1'b1;
      check_cmd("stall_c0", 1'b0);
      tick();
      check_cmd("stall_c1", 1'b0);
      tick();
      check_cmd("stall_c2", 1'b0);
      tick();
      in_stall = 1'b0;
      check_cmd("stall_c3", 1'b1);
      tick();
      check_idle("stall_clear");

      // fill the queue; fifth push is dropped
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill_ready_%0d", i), 64'(out_pred_ready), 64'd1);
         push_pred(64'h100 + 64'(4 * i), 1'b0, 1'b0, 64'h0);
      end
      chk("full_ready", 64'(out_pred_ready), 64'd0);
      push_pred(64'h110, 1'b0, 1'b0, 64'h0);
      chk("full_count", 64'(dut.u_fifo.count_q), 64'd4);
      resolve(1'b1, 64'h900);
      // wrong-path push lands in the same cycle as the redirect
      in_pred_valid = 1'b1; in_pred_pc = 64'h999; in_pred_hit = 1'b0;
      in_pred_taken = 1'b0; in_pred_target = '0;
      check_cmd("flush", 1'b1);
      tick();
      in_pred_valid = 1'b0;
      chk("flush_count", 64'(dut.u_fifo.count_q), 64'd0);
      chk("flush_ready", 64'(out_pred_ready), 64'd1);
      check_idle("flush_clear");

      // asynchronous reset while holding a command with three entries queued
      for (int i = 0; i < 4; i++) push_pred(64'h4000 + 64'(16 * i), 1'b1, 1'b1, 64'h8000);
      resolve(1'b1, 64'h8000);
      in_stall = 1'b1;
      tick();
      check_cmd("pre_reset_hold", 1'b1);
      chk("pre_reset_count", 64'(dut.u_fifo.count_q), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      chk("async_reset_count", 64'(dut.u_fifo.count_q), 64'd0);
      model_q.delete();
      exp_q.delete();
      in_stall = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      chk("post_reset_state", 64'(dut.state_q), 64'(IDLE));
      chk("post_reset_ready", 64'(out_pred_ready), 64'd1);
      check_idle("post_reset");

      // operation resumes after reset: hit predicted taken, actually not taken
      push_pred(64'h4000, 1'b1, 1'b1, 64'h4100);
      resolve(1'b0, 64'h0);
      check_cmd("post_reset_nt", 1'b1);
      tick();
      check_idle("post_reset_nt_clear");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the fetch-side branch target buffer (BTB).
- Records every fetch-time prediction in an in-order in-flight queue.
- Compares each entry against the branch outcome resolved in execute, and issues a front-end redirect when the two disagree.
- Produces the BTB allocate and 2-bit-counter update commands, holding them stable across pipeline stalls so no update is lost.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH), queue pointer width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_pred_valid  in  1  fetch issued a control-flow instruction this cycle
- in_pred_pc  in  64  PC of that instruction
- in_pred_hit  in  1  BTB hit (inverse of predictor miss)
- in_pred_taken  in  1  predicted taken
- in_pred_target  in  64  predicted next PC
- in_res_valid  in  1  execute resolved the oldest in-flight branch
- in_res_taken  in  1  actual direction
- in_res_target  in  64  actual taken target
- in_stall  in  1  OR of icache, dcache and hazard-unit stalls
- out_pred_ready  out  1  queue not full
- out_redirect  out  1  mispredict: flush younger instructions, load out_redirect_pc
- out_redirect_pc  out  64  corrected fetch PC
- out_write_to_bp  out  1  allocate BTB entry
- out_branch_source  out  64  PC to allocate
- out_branch_target  out  64  target to allocate
- out_is_update_state  out  1  update 2-bit counter
- out_source  out  64  PC whose counter is updated
- out_is_actual_branch_taken  out  1  counter direction

Behaviour:
- Reset: queue empty (head = tail = count = 0); every output is 0; FSM in IDLE. An asserted rst_n mid-operation discards all in-flight entries and any held command.
- Queue push:
  - Occurs when in_pred_valid && out_pred_ready && !in_stall.
  - Stores {pc, hit, taken, target}.
  - out_pred_ready = (count != DEPTH).
  - A push while full is dropped; fetch must not issue one.
- Queue pop:
  - Occurs when in_res_valid && count != 0 && FSM in IDLE && !in_stall.
  - in_res_valid while empty is ignored.
  - Push and pop in the same cycle leave count unchanged.
- Resolution, evaluated on the head entry:
  - actual_pc = in_res_taken ? in_res_target : pc + 4. Arithmetic is 64-bit and wraps modulo 2^64.
  - mispredict = (taken != in_res_taken) || (in_res_taken && target != in_res_target).
- Commands are registered and asserted the cycle after the pop:
  - out_redirect = mispredict; out_redirect_pc = actual_pc.
  - Hit entry: out_is_update_state = 1, out_source = pc, out_is_actual_branch_taken = in_res_taken.
  - Miss entry and actually taken: out_write_to_bp = 1, source = pc, target = in_res_target.
  - Miss entry and not taken: no BTB command.
  - Hit entry, taken, with a wrong target: both write and update are asserted for the same PC.
- FSM:
  - IDLE: goes to ISSUE on a pop.
  - ISSUE: commands are valid. If !in_stall → IDLE and all outputs clear next cycle. If in_stall → HOLD.
  - HOLD: outputs held unchanged; goes to IDLE on the first cycle with !in_stall, clearing outputs on the following edge.
  - Net effect: each command is seen by the BTB for exactly one unstalled cycle.
- Flush on mispredict:
  - In the cycle out_redirect is first asserted, the queue is emptied (head = tail, count = 0).
  - A simultaneous push is discarded (it is wrong-path).
- out_redirect is a single unstalled-cycle pulse, following the same hold rule as the BTB commands.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- Defined: adds outputs out_stat_resolved[31:0] and out_stat_mispredict[31:0].
  - Both are reset to 0.
  - Each increments once per command leaving ISSUE/HOLD (unstalled), mispredict only when out_redirect.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package branch_pkg:
  - typedef pred_entry_t {pc, hit, taken, target}.
  - typedef enum res_state_e {IDLE, ISSUE, HOLD}.
  - Constant INSN_BYTES = 4.
- One sub-module, pred_fifo: a parameterised DEPTH queue with push, pop, flush and count, whose flush has priority over push.

Test Plan:
- Hit entry, taken → actual taken:
  - Stimulus: push pc=0x1000, hit=1, taken=1, target=0x2000; resolve taken=1, target=0x2000.
  - Response: next cycle out_is_update_state=1, out_source=0x1000, dir=1, out_redirect=0.
- Miss entry, predicted not taken → actual taken:
  - Stimulus: push pc=0x1400, hit=0, taken=0; resolve taken=1, target=0x3000.
  - Response: out_write_to_bp=1, source=0x1400, target=0x3000, out_redirect=1, redirect_pc=0x3000, count=0.
- Hit entry, predicted taken → actual not taken:
  - Stimulus: push pc=0xFFFF_FFFF_FFFF_FFFC; resolve not taken.
  - Response: redirect_pc=0x0 (wrap), update dir=0.
- Stall during issue:
  - Stimulus: in_stall high for 3 cycles during ISSUE.
  - Response: commands held constant for those 3 cycles plus one unstalled cycle, then cleared; counter updated once.
- Full queue and flush with push:
  - Stimulus: fill 4 entries.
  - Response: out_pred_ready=0 and a 5th push is ignored.
  - Stimulus: mispredict on the head with a simultaneous push.
  - Response: count=0 afterwards.
- Reset mid-operation:
  - Stimulus: assert rst_n low during HOLD with 3 entries queued.
  - Response: all outputs 0 immediately (asynchronous), count=0, FSM IDLE after release.
